// File: rtl/commonlib_demuxn_deserializer.sv
// Serial-to-parallel deserializer: steers successive input words into N lanes and
// presents the filled lane set as one parallel word on a valid/ready output.
module commonlib_demuxn_deserializer #(
    parameter int unsigned N     = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [SEL_W-1:0]     in_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WIDTH-1:0]   out_data
);

    typedef enum logic [0:0] {StFill, StFull} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] lane_q [N];
    logic             lane_we;
    logic [SEL_W-1:0] lane_sel;
    logic             accept;
    logic             drain;

    always_comb begin
        in_ready = (state_q == StFill) | out_ready;
        accept   = in_valid & in_ready;
        drain    = (state_q == StFull) & out_ready;
        state_d  = state_q;
        idx_d    = idx_q;
        lane_we  = 1'b0;
        lane_sel = idx_q;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    lane_we = 1'b1;
                    // Wrap at N-1 explicitly so non-power-of-two N never sees idx >= N.
                    if (idx_q == SEL_W'(N - 1)) begin
                        idx_d   = '0;
                        state_d = StFull;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end
            end
            StFull: begin
                if (drain) begin
                    state_d = StFill;
                    // Back-to-back: the word arriving with the drain starts the next fill.
                    if (accept) begin
                        lane_we  = 1'b1;
                        lane_sel = '0;
                        idx_d    = SEL_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StFill;
            idx_q   <= '0;
            for (int k = 0; k < int'(N); k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int k = 0; k < int'(N); k++) begin
                if (lane_we && (lane_sel == SEL_W'(k))) begin
                    lane_q[k] <= in_data;
                end
            end
        end
    end

    assign out_valid = (state_q == StFull);
    assign in_sel    = idx_q;

    for (genvar k = 0; k < int'(N); k++) begin : g_lanes
        assign out_data[k*WIDTH +: WIDTH] = lane_q[k];
    end

endmodule

// File: tb/tb_commonlib_demuxn_deserializer.sv
// Bench for commonlib_demuxn_deserializer: an N=8/WIDTH=8 and an N=5/WIDTH=4 instance
// checked against a queue-of-accepted-words reference model.
module tb_commonlib_demuxn_deserializer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  in_data8 = '0;
    logic [2:0]  in_sel8;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [63:0] out_data8;

    logic        in_valid5 = 1'b0;
    logic        in_ready5;
    logic [3:0]  in_data5 = '0;
    logic [2:0]  in_sel5;
    logic        out_valid5;
    logic        out_ready5 = 1'b0;
    logic [19:0] out_data5;

    always #5 CLK = ~CLK;

    commonlib_demuxn_deserializer #(.N(8), .WIDTH(8)) dut8 (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_sel(in_sel8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
    );

    commonlib_demuxn_deserializer #(.N(5), .WIDTH(4)) dut5 (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5), .in_sel(in_sel5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: words accepted since reset and not yet delivered, in arrival order.
    logic [7:0] q8[$];
    logic [3:0] q5[$];
    int accepts8 = 0, drains8 = 0, drains5 = 0;

    logic        s_valid, s_ready;
    logic [2:0]  s_sel;
    logic [63:0] s_data;
    logic [19:0] s5_data;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        ev;
        logic [2:0]  esel;
        logic        er;
        logic        cd;
        logic [63:0] edata;
    } vec_t;

    vec_t tbl[10];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, check at the falling edge, then advance model.
    task automatic tick8(input logic v, input logic [7:0] d, input logic r);
        logic        ev, er, acc, drn;
        logic [63:0] ed;
        in_valid8  = v;
        in_data8   = d;
        out_ready8 = r;
        @(negedge CLK);
        ev = (q8.size() == 8);
        er = !ev || r;
        cmp("out_valid8", {63'd0, out_valid8}, {63'd0, ev});
        cmp("in_ready8", {63'd0, in_ready8}, {63'd0, er});
        cmp("in_sel8", {61'd0, in_sel8}, 64'(q8.size() % 8));
        if (ev) begin
            ed = '0;
            for (int k = 0; k < 8; k++) ed[k*8 +: 8] = q8[k];
            cmp("out_data8", out_data8, ed);
        end
        s_valid = out_valid8;
        s_ready = in_ready8;
        s_sel   = in_sel8;
        s_data  = out_data8;
        acc = v && er;
        drn = ev && r;
        @(posedge CLK);
        if (drn) begin
            repeat (8) void'(q8.pop_front());
            drains8++;
        end
        if (acc) begin
            q8.push_back(d);
            accepts8++;
        end
        #1;
    endtask

    task automatic tick5(input logic v, input logic [3:0] d, input logic r);
        logic        ev, er, acc, drn;
        logic [19:0] ed;
        in_valid5  = v;
        in_data5   = d;
        out_ready5 = r;
        @(negedge CLK);
        ev = (q5.size() == 5);
        er = !ev || r;
        cmp("out_valid5", {63'd0, out_valid5}, {63'd0, ev});
        cmp("in_ready5", {63'd0, in_ready5}, {63'd0, er});
        cmp("in_sel5", {61'd0, in_sel5}, 64'(q5.size() % 5));
        if (ev) begin
            ed = '0;
            for (int k = 0; k < 5; k++) ed[k*4 +: 4] = q5[k];
            cmp("out_data5", {44'd0, out_data5}, {44'd0, ed});
        end
        s5_data = out_data5;
        acc = v && er;
        drn = ev && r;
        @(posedge CLK);
        if (drn) begin
            repeat (5) void'(q5.pop_front());
            drains5++;
        end
        if (acc) q5.push_back(d);
        #1;
    endtask

    // Reset with live traffic on both inputs; reset must win over any accept/drain.
    task automatic rst();
        RESET      = 1'b1;
        in_valid8  = 1'b1;
        in_data8   = 8'hEE;
        out_ready8 = 1'b1;
        in_valid5  = 1'b1;
        in_data5   = 4'hE;
        out_ready5 = 1'b1;
        @(posedge CLK);
        #1;
        RESET     = 1'b0;
        in_valid8 = 1'b0;
        in_valid5 = 1'b0;
        q8.delete();
        q5.delete();
        @(negedge CLK);
        cmp("rst_out_data8", out_data8, 64'd0);
        cmp("rst_out_valid8", {63'd0, out_valid8}, 64'd0);
        cmp("rst_in_sel8", {61'd0, in_sel8}, 64'd0);
        cmp("rst_in_ready8", {63'd0, in_ready8}, 64'd1);
        cmp("rst_out_data5", {44'd0, out_data5}, 64'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0, r0, cyc;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{v: 1'b1, d: 8'(8'h10 + i), r: 1'b1, ev: 1'b0, esel: 3'(i), er: 1'b1,
                       cd: 1'b0, edata: 64'd0};
        end
        tbl[8] = '{v: 1'b0, d: 8'h00, r: 1'b1, ev: 1'b1, esel: 3'd0, er: 1'b1,
                   cd: 1'b1, edata: 64'h1716_1514_1312_1110};
        tbl[9] = '{v: 1'b0, d: 8'h00, r: 1'b0, ev: 1'b0, esel: 3'd0, er: 1'b1,
                   cd: 1'b0, edata: 64'd0};

        repeat (2) @(posedge CLK);
        #1;
        rst();

        // Basic fill of 0x10..0x17 and the resulting output word.
        for (int i = 0; i < 10; i++) begin
            tick8(tbl[i].v, tbl[i].d, tbl[i].r);
            cmp("tbl_valid", {63'd0, s_valid}, {63'd0, tbl[i].ev});
            cmp("tbl_sel", {61'd0, s_sel}, {61'd0, tbl[i].esel});
            cmp("tbl_ready", {63'd0, s_ready}, {63'd0, tbl[i].er});
            if (tbl[i].cd) cmp("tbl_data", s_data, tbl[i].edata);
        end

        // Continuous 24-word stream with out_ready held high.
        rst();
        d0 = drains8;
        for (int i = 0; i < 24; i++) tick8(1'b1, 8'(i), 1'b1);
        tick8(1'b0, 8'h00, 1'b1);
        cmp("stream_outputs", 64'(drains8 - d0), 64'd3);

        // Output stall with a pending word, then drain plus accept in the same cycle.
        rst();
        for (int i = 0; i < 8; i++) tick8(1'b1, 8'(8'h30 + i), 1'b0);
        repeat (5) tick8(1'b1, 8'hAA, 1'b0);
        cmp("stall_data", s_data, 64'h3736_3534_3332_3130);
        tick8(1'b1, 8'hAA, 1'b1);
        tick8(1'b0, 8'h00, 1'b0);
        cmp("stall_sel_after", {61'd0, s_sel}, 64'd1);
        cmp("stall_lane0", {56'd0, s_data[7:0]}, 64'hAA);

        // Reset mid-fill, then a clean fill.
        rst();
        for (int i = 1; i <= 3; i++) tick8(1'b1, 8'(i), 1'b1);
        rst();
        for (int i = 0; i < 8; i++) tick8(1'b1, 8'(8'h20 + i), 1'b1);
        tick8(1'b0, 8'h00, 1'b0);
        cmp("refill_data", s_data, 64'h2726_2524_2322_2120);

        // Reset while full and stalled.
        rst();
        for (int i = 0; i < 8; i++) tick8(1'b1, 8'(8'h40 + i), 1'b0);
        tick8(1'b0, 8'h00, 1'b0);
        rst();

        // Non-power-of-two lane count.
        d0 = drains5;
        for (int i = 1; i <= 5; i++) tick5(1'b1, 4'(i), 1'b1);
        tick5(1'b0, 4'h0, 1'b0);
        cmp("n5_first", {44'd0, s5_data}, 64'h5_4321);
        for (int i = 6; i <= 10; i++) tick5(1'b1, 4'(i), 1'b1);
        tick5(1'b0, 4'h0, 1'b0);
        cmp("n5_second", {44'd0, s5_data}, 64'hA_9876);
        tick5(1'b0, 4'h0, 1'b1);
        cmp("n5_outputs", 64'(drains5 - d0), 64'd2);

        // Random valid/ready gaps over 1000 words.
        rst();
        a0  = accepts8;
        r0  = drains8;
        cyc = 0;
        while ((accepts8 - a0) < 1000 && cyc < 20000) begin
            tick8(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)));
            cyc++;
        end
        cmp("random_accepts", 64'(accepts8 - a0), 64'd1000);
        repeat (2) tick8(1'b0, 8'h00, 1'b1);
        cmp("random_outputs", 64'(drains8 - r0), 64'd125);
        cmp("random_leftover", 64'(q8.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commonlib_demuxn_deserializer.md
Name: commonlib_demuxn_deserializer

Overview:
- Time-domain inverse of the muxn tree. Accepts a stream of WIDTH-bit words on a valid/ready input and steers word k to output lane k, k = 0..N-1.
- Once all N lanes are filled, presents them together as one N-lane parallel word on a valid/ready output.
- Sits on the receive side of a path whose transmit side serialises N lanes through a muxn driven by an incrementing select.

Parameters:
- N, 8, number of output lanes; integer >= 2, power of two not required.
- WIDTH, 8, bits per lane.
- SEL_W, max(1, clog2(N)), width of the lane index.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  serial input word.
- in_sel  output  SEL_W  lane index the next accepted word will be written to.
- out_valid  output  1  out_data holds a complete N-lane word.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  N*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].

Behaviour:
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- State machine has two states, FILL and FULL. Reset state is FILL.
- Reset values: idx = 0, in_sel = 0, out_valid = 0, out_data = 0, in_ready = 1 (combinational from FILL).
- FILL:
  - in_ready = 1, out_valid = 0.
  - On accept: lane[idx] <= in_data.
  - If idx == N-1: idx <= 0 and go to FULL. Otherwise idx <= idx+1.
  - No accept: all state holds, including partially filled lanes.
- FULL:
  - out_valid = 1, idx = 0.
  - in_ready = out_ready (combinational pass-through).
  - On drain without accept: go to FILL.
  - On drain with accept in the same cycle: lane[0] <= in_data, idx <= 1, go to FILL.
  - Stall (out_ready = 0): out_data and out_valid hold stable. No input is accepted.
- Latency: out_valid rises on the clock edge that accepts the Nth word, i.e. it is first visible the cycle after that accept.
- Throughput:
  - Sustains one word per cycle with no bubbles when out_ready is held high.
  - One output every N cycles.
- Lanes not yet rewritten in the current fill keep their previous values. out_data is only meaningful while out_valid = 1.
- in_sel equals idx at all times. Index wrap is at N-1, not at 2^SEL_W-1; this matters for non-power-of-two N.
- Outputs are registered except in_ready, which is combinational from state and out_ready only.
- in_data is ignored when in_valid = 0. out_ready is ignored in FILL.
- RESET has priority over all events, including accept/drain in the same cycle.
- Reset mid-fill or while FULL discards all lanes, clears out_data to 0 and returns to FILL with idx = 0.
- No protocol errors are flagged. The upstream side may drop in_valid between words with no effect besides the stall.

Test Plan:
- Reset, then drive 0x10..0x17 on 8 consecutive cycles with out_ready=1 -> out_valid high exactly one cycle after the 8th accept; out_data lanes 0..7 = 0x10..0x17; in_sel steps 0..7 then wraps to 0.
- Continuous stream 0x00..0x17 (24 words), out_ready=1 -> in_ready never drops; three outputs at 8-cycle spacing: 0x00..07, 0x08..0F, 0x10..17.
- Fill 8 words, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0; out_data stable; on out_ready=1 the pending word 0xAA is written to lane 0 in that same cycle and in_sel=1 next cycle.
- Feed 3 words (0x01,0x02,0x03), assert RESET one cycle -> out_data=0, out_valid=0, in_sel=0; then 8 new words 0x20..0x27 appear in lanes 0..7 with no residue from the first 3.
- N=5, WIDTH=4: feed 0x1..0xA -> two outputs, {0x1..0x5} then {0x6..0xA}; in_sel sequence 0,1,2,3,4,0 with no values 5..7.
- Random in_valid/out_ready gaps (50%), 1000 words -> output lanes match a scoreboard built from the input order; no word lost or duplicated.
